// File: rtl/fir_serial_mac.sv
`default_nettype none
// ============================================================================
// Module      : fir_serial_mac
// Description : Time-multiplexed FIR filter. One multiply-accumulate per clock
//               over a circular sample history, coefficients fetched from an
//               external synchronous ROM. Full-precision signed accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_serial_mac #(
    parameter  int DATA_W = 16,
    parameter  int COEF_W = 16,
    parameter  int TAPS   = 32,
    localparam int AW     = $clog2(TAPS),
    localparam int ACC_W  = DATA_W + COEF_W + AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic signed [DATA_W-1:0] in_data,
    output logic        [AW-1:0]     coef_addr,
    input  logic signed [COEF_W-1:0] coef_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [ACC_W-1:0]  out_acc
);

    localparam int PROD_W = DATA_W + COEF_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_MAC   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;

    logic [AW-1:0]            r_k;
    logic [AW-1:0]            r_wr_ptr;
    logic signed [DATA_W-1:0] r_hist [TAPS];
    logic signed [DATA_W-1:0] r_samp;
    logic                     r_samp_vld;
    logic signed [PROD_W-1:0] r_prod;
    logic                     r_prod_vld;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_out_valid;

    logic                     w_accept;
    logic                     w_out_fire;
    logic                     w_last_tap;
    logic [AW-1:0]            w_rd_idx;
    logic signed [PROD_W-1:0] w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;

    assign w_accept   = in_valid && (r_state == S_IDLE);
    assign w_out_fire = r_out_valid && out_ready;
    assign w_last_tap = (r_k == AW'(TAPS - 1));
    // Subtraction in AW bits gives the modulo-TAPS wrap for free.
    assign w_rd_idx   = r_wr_ptr - r_k;
    assign w_prod     = coef_data * r_samp;
    assign w_prod_ext = {{AW{r_prod[PROD_W-1]}}, r_prod};

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: IDLE -> MAC (TAPS cycles) -> DRAIN -> OUT -> IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept)   w_state_nxt = S_MAC;
            S_MAC:   if (w_last_tap) w_state_nxt = S_DRAIN;
            S_DRAIN:                 w_state_nxt = S_OUT;
            S_OUT:   if (w_out_fire) w_state_nxt = S_IDLE;
            default:                 w_state_nxt = S_IDLE;
        endcase
    end

    // Moore outputs: ready only when idle, ROM address only while MACing.
    always_comb begin
        in_ready  = 1'b0;
        coef_addr = '0;
        case (r_state)
            S_IDLE: in_ready  = 1'b1;
            S_MAC:  coef_addr = r_k;
            default: ;
        endcase
    end

    // Tap index and history write pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k      <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (r_state == S_MAC) begin
                r_k <= w_last_tap ? '0 : r_k + AW'(1);
            end else begin
                r_k <= '0;
            end
            if ((r_state == S_OUT) && w_out_fire) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
        end
    end

    // Sample history: written only on an accepted sample.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                r_hist[i] <= '0;
            end
        end else if (w_accept) begin
            r_hist[r_wr_ptr] <= in_data;
        end
    end

    // MAC pipeline: sample fetch aligned with ROM latency, then product
    // register, then accumulate. The last product lands two edges after
    // the final MAC cycle, which sets the result latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp      <= '0;
            r_samp_vld  <= 1'b0;
            r_prod      <= '0;
            r_prod_vld  <= 1'b0;
            r_acc       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_samp     <= r_hist[w_rd_idx];
            r_samp_vld <= (r_state == S_MAC);
            r_prod     <= w_prod;
            r_prod_vld <= r_samp_vld;

            if (w_accept) begin
                r_acc <= '0;
            end else if (r_prod_vld) begin
                r_acc <= r_acc + w_prod_ext;
            end

            if (w_out_fire) begin
                r_out_valid <= 1'b0;
            end else if ((r_state == S_OUT) && r_prod_vld) begin
                r_out_valid <= 1'b1;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_acc   = r_acc;

endmodule
`default_nettype wire
